hs_sync_rx_ctrl: RTL and testbench
==================================

HS_SYNC_RX_CTRL -- requirements
Module: hs_sync_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of transferred word.
REQ-002 SHALL have parameter NUM_STAGES, default 2, synchronizer depth for src_req (legal range 2..4).
REQ-003 SHALL have port clk  input  1  destination-domain clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port src_req  input  1  level request from the source domain, asynchronous to clk.
REQ-006 SHALL have port src_data  input  DATA_WIDTH  source word, held stable by the source from src_req rise until src_ack is seen high.
REQ-007 SHALL have port src_ack  output  1  registered level acknowledge back to the source domain.
REQ-008 SHALL have port dst_valid  output  1  registered, dst_data holds a valid word.
REQ-009 SHALL have port dst_ready  input  1  consumer accepts word when high with dst_valid.
REQ-010 SHALL have port dst_data  output  DATA_WIDTH  registered captured word.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port xfer_cnt  output  8  count of completed transfers, wraps 255->0.

Function
REQ-013 SHALL pass src_req through a NUM_STAGES flip-flop chain (each flop reset to 0); only the last stage (req_s) SHALL be used by the control logic.
REQ-014 SHALL never sample src_req or src_data combinationally into outputs; src_data SHALL be sampled only on the capture edge.
REQ-015 SHALL implement a 3-state FSM: IDLE, VALID, ACK.
REQ-016 IDLE: src_ack=0, dst_valid=0; if req_s=1, capture src_data into dst_data, set dst_valid=1, go VALID.
REQ-017 VALID: dst_valid=1, dst_data stable; on an edge with dst_ready=1, clear dst_valid, set src_ack=1, increment xfer_cnt, go ACK.
REQ-018 VALID with dst_ready=0 SHALL hold indefinitely; req_s changes in VALID SHALL be ignored.
REQ-019 ACK: src_ack=1; when req_s=0, clear src_ack, go IDLE; otherwise hold.
REQ-020 Latency: src_req rising before edge 1 -> req_s=1 after NUM_STAGES edges -> dst_valid=1 after NUM_STAGES+1 edges.
REQ-021 dst_ready may already be high when dst_valid rises; acceptance then occurs on the next edge (one-cycle minimum valid pulse).
REQ-022 A new word SHALL NOT be captured until the FSM has returned to IDLE with req_s=0 seen in ACK (strict 4-phase; no back-to-back capture on one req level).
REQ-023 dst_data SHALL retain the last captured word after acceptance until the next capture.
REQ-024 src_req glitch shorter than one clk period that never reaches req_s SHALL produce no transfer.
REQ-025 xfer_cnt SHALL increment exactly once per accepted word and wrap modulo 256.

Reset
REQ-026 On rst=0, asynchronously: synchronizer stages=0, state=IDLE, src_ack=0, dst_valid=0, dst_data=0, busy=0, xfer_cnt=0.
REQ-027 Reset mid-transfer SHALL abandon the transfer; if src_req is still high after rst release, it SHALL be treated as a new request and delivered after NUM_STAGES+1 edges.
REQ-028 rst release SHALL be synchronous to clk externally; no state change on the release edge other than synchronizer shifting.

Verification
REQ-029 NUM_STAGES=2, dst_ready=1, src_data=0xA5, src_req 0->1 -> dst_valid=1 with dst_data=0xA5 on edge 3, src_ack=1 on edge 4, xfer_cnt=1.
REQ-030 dst_ready=0 for 10 cycles after dst_valid -> dst_valid and dst_data=0x3C held 10 cycles, src_ack=0 throughout; ready=1 -> ack next edge.
REQ-031 src_req held high after ack -> FSM stays ACK, no second dst_valid; src_req 0 -> src_ack 0 after 2 edges + 1, busy=0.
REQ-032 256 full handshakes with incrementing data 0x00..0xFF -> every word delivered once in order, xfer_cnt returns to 0.
REQ-033 rst asserted in VALID with src_req=1 -> all outputs 0 immediately; after release, word redelivered at edge 3, xfer_cnt=1.
REQ-034 src_req high for 0.3 clk period between edges -> no dst_valid, no src_ack, busy stays 0.

Source files
------------

// File: rtl/hs_sync_rx_ctrl.sv
// Destination side of a 4-phase req/ack clock-domain crossing: synchronizes
// src_req, captures src_data into a valid/ready output, and acknowledges back.
module hs_sync_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  src_req,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ack,
  output logic                  dst_valid,
  input  logic                  dst_ready,
  output logic [DATA_WIDTH-1:0] dst_data,
  output logic                  busy,
  output logic [7:0]            xfer_cnt,
  output logic [1:0]            state_dbg
);

  // Handshake: a word moves to the consumer on a rising edge where
  // dst_valid && dst_ready are both high; dst_valid never drops without that.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [NUM_STAGES-1:0] sync_q;
  logic                  req_s;
  logic                  capture;
  logic                  accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[NUM_STAGES-2:0], src_req};
  end

  assign req_s = sync_q[NUM_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_s)     state_d = VALID;
      VALID:   if (dst_ready) state_d = ACK;
      ACK:     if (!req_s)    state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    capture   = (state_q == IDLE) && req_s;
    accept    = (state_q == VALID) && dst_ready;
    busy      = (state_q != IDLE);
    state_dbg = state_q;
  end

  // Flag outputs are registered from the next state so they change on the
  // same edge as the state itself, with no decode glitches toward the source.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dst_valid <= 1'b0;
      src_ack   <= 1'b0;
      dst_data  <= '0;
      xfer_cnt  <= 8'd0;
    end else begin
      dst_valid <= (state_d == VALID);
      src_ack   <= (state_d == ACK);
      if (capture) dst_data <= src_data;
      if (accept)  xfer_cnt <= xfer_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_hs_sync_rx_ctrl.sv
// Directed bench for hs_sync_rx_ctrl: latency, backpressure, 4-phase hold,
// 256-word wrap, mid-transfer reset and sub-cycle request glitch.
module tb_hs_sync_rx_ctrl;

  logic       clk;
  logic       rst;
  logic       src_req;
  logic [7:0] src_data;
  logic       src_ack;
  logic       dst_valid;
  logic       dst_ready;
  logic [7:0] dst_data;
  logic       busy;
  logic [7:0] xfer_cnt;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_err    = 0;

  hs_sync_rx_ctrl #(.DATA_WIDTH(8), .NUM_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_req   (src_req),
    .src_data  (src_data),
    .src_ack   (src_ack),
    .dst_valid (dst_valid),
    .dst_ready (dst_ready),
    .dst_data  (dst_data),
    .busy      (busy),
    .xfer_cnt  (xfer_cnt),
    .state_dbg (state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ack"},   {31'd0, src_ack},   32'd0);
    chk({tag, "_valid"}, {31'd0, dst_valid}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy},      32'd0);
  endtask

  // One full 4-phase transfer with dst_ready high; every wait is bounded.
  task automatic handshake(input logic [7:0] d, input logic [7:0] exp_cnt);
    int n;
    src_data = d;
    src_req  = 1'b1;
    n = 0;
    while (!dst_valid && n < 10) begin tick(1); n++; end
    chk("hs_valid_seen", {31'd0, dst_valid}, 32'd1);
    chk("hs_data", {24'd0, dst_data}, {24'd0, d});
    n = 0;
    while (!src_ack && n < 10) begin tick(1); n++; end
    chk("hs_cnt", {24'd0, xfer_cnt}, {24'd0, exp_cnt});
    src_req = 1'b0;
    n = 0;
    while (src_ack && n < 10) begin tick(1); n++; end
    chk("hs_ack_drop", {31'd0, src_ack}, 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    src_req   = 1'b0;
    src_data  = 8'h00;
    dst_ready = 1'b1;
    #1;
    chk_idle("reset");
    chk("reset_data", {24'd0, dst_data}, 32'd0);
    chk("reset_cnt",  {24'd0, xfer_cnt}, 32'd0);
    tick(2);
    rst = 1'b1;

    // Basic latency: valid on edge 3, ack on edge 4.
    src_data = 8'hA5;
    src_req  = 1'b1;
    tick(2);
    chk("lat_e2_valid", {31'd0, dst_valid}, 32'd0);
    tick(1);
    chk("lat_e3_valid", {31'd0, dst_valid}, 32'd1);
    chk("lat_e3_data",  {24'd0, dst_data},  32'hA5);
    chk("lat_e3_ack",   {31'd0, src_ack},   32'd0);
    chk("lat_e3_busy",  {31'd0, busy},      32'd1);
    tick(1);
    chk("lat_e4_ack",   {31'd0, src_ack},   32'd1);
    chk("lat_e4_valid", {31'd0, dst_valid}, 32'd0);
    chk("lat_e4_cnt",   {24'd0, xfer_cnt},  32'd1);
    src_req = 1'b0;
    tick(2);
    chk("drop_e2_ack", {31'd0, src_ack}, 32'd1);
    tick(1);
    chk_idle("drop_e3");
    chk("retain_data", {24'd0, dst_data}, 32'hA5);

    // Backpressure for 10 cycles, then acceptance on the next edge.
    dst_ready = 1'b0;
    src_data  = 8'h3C;
    src_req   = 1'b1;
    tick(3);
    chk("bp_valid_rise", {31'd0, dst_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("bp_hold_valid", {31'd0, dst_valid}, 32'd1);
      chk("bp_hold_data",  {24'd0, dst_data},  32'h3C);
      chk("bp_hold_ack",   {31'd0, src_ack},   32'd0);
    end
    dst_ready = 1'b1;
    tick(1);
    chk("bp_ack",   {31'd0, src_ack},   32'd1);
    chk("bp_valid", {31'd0, dst_valid}, 32'd0);
    chk("bp_cnt",   {24'd0, xfer_cnt},  32'd2);

    // Request left high: must stay in ACK with no second capture.
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("hold_ack",   {31'd0, src_ack},   32'd1);
      chk("hold_valid", {31'd0, dst_valid}, 32'd0);
      chk("hold_state", {30'd0, state_dbg}, 32'd2);
    end
    chk("hold_cnt", {24'd0, xfer_cnt}, 32'd2);
    src_req = 1'b0;
    tick(2);
    chk("hold_drop_e2", {31'd0, src_ack}, 32'd1);
    tick(1);
    chk_idle("hold_drop_e3");

    // Reset while VALID with the request still high.
    src_data = 8'h5A;
    src_req  = 1'b1;
    tick(3);
    chk("rstm_valid", {31'd0, dst_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_idle("rstm_async");
    chk("rstm_data", {24'd0, dst_data}, 32'd0);
    chk("rstm_cnt",  {24'd0, xfer_cnt}, 32'd0);
    tick(2);
    rst = 1'b1;
    tick(2);
    chk("rstm_e2_valid", {31'd0, dst_valid}, 32'd0);
    tick(1);
    chk("rstm_e3_valid", {31'd0, dst_valid}, 32'd1);
    chk("rstm_e3_data",  {24'd0, dst_data},  32'h5A);
    tick(1);
    chk("rstm_e4_ack", {31'd0, src_ack},  32'd1);
    chk("rstm_e4_cnt", {24'd0, xfer_cnt}, 32'd1);
    src_req = 1'b0;
    tick(3);
    chk_idle("rstm_done");

    // Sub-cycle glitch on src_req between two edges.
    tick(1);
    #2 src_req = 1'b1;
    #3 src_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk_idle("glitch");
    end
    chk("glitch_cnt", {24'd0, xfer_cnt}, 32'd1);

    // 256 handshakes from a clean reset: counter wraps back to zero.
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] d;
      d = i[7:0];
      handshake(d, d + 8'd1);
    end
    chk("wrap_cnt",  {24'd0, xfer_cnt}, 32'd0);
    chk("wrap_last", {24'd0, dst_data}, 32'hFF);
    chk_idle("wrap_end");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
